core_sequencer: RTL and testbench

Multi-cycle control sequencer for the single-issue RV32 datapath (PC, instruction memory, register file, ALU, seven-segment readout). It owns the program counter and walks each instruction through fetch, execute and write-back. It gates register-file writes, so results commit only in a defined cycle. Steps are triggered by a free-running tick (run mode) or by a debounced press of the board button (single-step mode). It halts on an unsupported opcode.

---
 rtl/core_sequencer.sv | 128 ++++++++++++
 tb/tb_core_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: owns the PC, walks each instruction through
// FETCH/EXEC/WB, gates register writes and halts on unsupported opcodes.
`timescale 1ns/1ps
module core_sequencer #(
  parameter int MEM_SIZE = 64,
  parameter int TICK_DIV = 50000000,
  parameter int DEBOUNCE = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        button,
  input  logic        run_mode,
  input  logic [6:0]  opcode,
  output logic [31:0] pc,
  output logic        ir_load,
  output logic        reg_we,
  output logic        step_done,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [31:0]     PC_LIMIT  = 32'(MEM_SIZE - 4);
  localparam logic [6:0]      OPCODE_I  = 7'b0010011;
  localparam logic [6:0]      OPCODE_R  = 7'b0110011;
  localparam logic [6:0]      OPCODE_NOP = 7'b0000000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  logic            r_sync1, r_sync2, r_btn_level;
  logic [DB_W-1:0] r_db_cnt;
  logic [TK_W-1:0] r_tick_cnt;
  state_t          r_state, w_state_next;
  logic [31:0]     r_pc, w_pc_plus4, w_next_pc;
  logic            r_wb_write, w_wb_write_next;
  logic            w_tick, w_btn_press, w_go;

  // The counter holds only DEBOUNCE-1 values: the DEBOUNCE-th mismatching
  // cycle is the one that accepts the new level.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_btn_level <= 1'b0;
      r_db_cnt    <= '0;
    end else begin
      r_sync1 <= button;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_btn_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_btn_level <= r_sync2;
        r_db_cnt    <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  assign w_btn_press = r_sync2 & ~r_btn_level & (r_db_cnt == DB_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TK_W'(1);
    end
  end

  assign w_tick     = (r_tick_cnt == TICK_LAST);
  assign w_go       = run_mode ? w_tick : w_btn_press;
  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_next_pc  = (w_pc_plus4 > PC_LIMIT) ? 32'd0 : w_pc_plus4;

  always_comb begin
    w_state_next    = r_state;
    w_wb_write_next = r_wb_write;
    case (r_state)
      S_IDLE:  if (w_go) w_state_next = S_FETCH;
      S_FETCH: w_state_next = S_EXEC;
      S_EXEC: begin
        if ((opcode == OPCODE_I) || (opcode == OPCODE_R)) begin
          w_state_next    = S_WB;
          w_wb_write_next = 1'b1;
        end else if (opcode == OPCODE_NOP) begin
          w_state_next    = S_WB;
          w_wb_write_next = 1'b0;
        end else begin
          w_state_next    = S_HALT;
          w_wb_write_next = 1'b0;
        end
      end
      S_WB:    w_state_next = S_IDLE;
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= 32'd0;
      r_wb_write <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wb_write <= w_wb_write_next;
      if (r_state == S_WB) r_pc <= w_next_pc;
    end
  end

  // Strobes come only from registered state, never from button/opcode.
  assign pc        = r_pc;
  assign ir_load   = (r_state == S_FETCH);
  assign reg_we    = (r_state == S_WB) & r_wb_write;
  assign step_done = (r_state == S_WB);
  assign halted    = (r_state == S_HALT);
  assign state     = r_state;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: vector table in run mode, hand
// sequences for debounce/halt/reset corners, randomized steps vs a PC model.
`timescale 1ns/1ps
module tb_core_sequencer;

  localparam int MEM = 64;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        button = 1'b0;
  logic        run_mode = 1'b1;
  logic [6:0]  opcode = 7'h13;
  logic [31:0] pc;
  logic        ir_load, reg_we, step_done, halted;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  core_sequencer #(.MEM_SIZE(MEM), .TICK_DIV(10), .DEBOUNCE(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .button(button), .run_mode(run_mode),
    .opcode(opcode), .pc(pc), .ir_load(ir_load), .reg_we(reg_we),
    .step_done(step_done), .halted(halted), .state(state)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [6:0]  op;
    logic [31:0] exp_pc;
    logic        exp_we;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    sys_rst = 1'b1;
    repeat (n) cyc();
    sys_rst = 1'b0;
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] p);
    return (p + 32'd4) % MEM;
  endfunction

  function automatic logic model_we(input logic [6:0] op);
    return (op == 7'h13) || (op == 7'h33);
  endfunction

  task automatic wait_fetch(input int max, output int waited);
    waited = 0;
    while (!ir_load && waited < max) begin
      cyc();
      waited++;
    end
    chk("fetch_seen", ir_load, 1);
  endtask

  // Called in the FETCH cycle; leaves the bench in the following IDLE cycle.
  task automatic run_instr(input logic [6:0] op, input logic [31:0] pc0,
                           input logic [31:0] pc1, input logic we);
    chk("fetch_state", state, 1);
    chk("fetch_pc", pc, pc0);
    cyc();
    chk("exec_state", state, 2);
    chk("exec_strobes", {ir_load, reg_we, step_done}, 0);
    cyc();
    chk("wb_state", state, 3);
    chk("wb_reg_we", reg_we, we);
    chk("wb_step_done", step_done, 1);
    chk("wb_pc_held", pc, pc0);
    cyc();
    chk("idle_state", state, 0);
    chk("idle_pc", pc, pc1);
    chk("idle_strobes", {ir_load, reg_we, step_done}, 0);
    $display("step op=0x%02h pc %0d -> %0d we=%0d", op, pc0, pc, we);
  endtask

  task automatic press_step(input logic [6:0] op, inout logic [31:0] mpc);
    int w;
    int extra;
    opcode = op;
    button = 1'b1;
    wait_fetch(20, w);
    chk("btn_latency_ok", (w >= 5 && w <= 8), 1);
    if (ir_load) begin
      run_instr(op, mpc, model_next(mpc), model_we(op));
      mpc = model_next(mpc);
    end
    extra = 0;
    repeat (10) begin cyc(); if (ir_load) extra++; end
    button = 1'b0;
    repeat (12) begin cyc(); if (ir_load) extra++; end
    chk("one_step_per_press", extra, 0);
  endtask

  vec_t        tbl[18];
  logic [31:0] mpc;
  int          w, first, bad;

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].op     = (i == 5 || i == 11) ? 7'h00 : ((i % 2) ? 7'h33 : 7'h13);
      tbl[i].exp_pc = ((i + 1) * 4) % MEM;
      tbl[i].exp_we = (tbl[i].op != 7'h00);
    end

    // Reset state and first-tick alignment
    run_mode = 1'b1;
    opcode   = tbl[0].op;
    do_reset(3);
    chk("rst_pc", pc, 0);
    chk("rst_state", state, 0);
    chk("rst_strobes", {ir_load, reg_we, step_done, halted}, 0);
    first = 0;
    for (int k = 1; k <= 30; k++) begin
      cyc();
      if (ir_load) begin first = k; break; end
    end
    chk("first_tick_cycle", first, 10);

    // Run-mode table: I/R/empty instructions, pc walks 0..60 and wraps
    mpc = 32'd0;
    for (int i = 0; i < 18; i++) begin
      opcode = tbl[i].op;
      if (i > 0) begin
        wait_fetch(15, w);
        chk("tick_period", w, 7);
      end
      if (ir_load) run_instr(tbl[i].op, mpc, tbl[i].exp_pc, tbl[i].exp_we);
      mpc = tbl[i].exp_pc;
    end

    // Single-step: glitch ignored, then two real presses
    run_mode = 1'b0;
    do_reset(1);
    mpc = 32'd0;
    button = 1'b1;
    repeat (3) cyc();
    button = 1'b0;
    bad = 0;
    repeat (15) begin cyc(); if (ir_load) bad++; end
    chk("glitch_no_step", bad, 0);
    chk("glitch_pc", pc, 0);
    press_step(7'h13, mpc);
    chk("press1_pc", pc, 4);
    press_step(7'h33, mpc);
    chk("press2_pc", pc, 8);

    // Illegal opcode halts at pc 8 and ignores further triggers
    opcode = 7'h63;
    button = 1'b1;
    wait_fetch(20, w);
    cyc();
    chk("ill_exec_state", state, 2);
    cyc();
    chk("halt_state", state, 4);
    chk("halt_flag", halted, 1);
    chk("halt_pc", pc, 8);
    chk("halt_strobes", {ir_load, reg_we, step_done}, 0);
    bad = 0;
    run_mode = 1'b1;
    for (int k = 0; k < 36; k++) begin
      if (k == 12) button = 1'b0;
      if (k == 24) button = 1'b1;
      cyc();
      if (state != 3'd4 || reg_we || step_done || ir_load || pc != 32'd8) bad++;
    end
    button = 1'b0;
    chk("halt_absorbing", bad, 0);
    $display("halt held at pc=%0d for 36 cycles", pc);
    do_reset(1);
    chk("unhalt_pc", pc, 0);
    chk("unhalt_flag", halted, 0);
    chk("unhalt_state", state, 0);

    // Randomized steps against the PC/write model
    mpc = 32'd0;
    for (int it = 0; it < 24; it++) begin
      logic [6:0] op;
      case ($urandom_range(0, 2))
        0:       op = 7'h13;
        1:       op = 7'h33;
        default: op = 7'h00;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        run_mode = 1'b1;
        opcode   = op;
        wait_fetch(25, w);
        if (ir_load) begin
          run_instr(op, mpc, model_next(mpc), model_we(op));
          mpc = model_next(mpc);
        end
      end else begin
        run_mode = 1'b0;
        repeat ($urandom_range(0, 5)) cyc();
        press_step(op, mpc);
      end
    end
    chk("rand_final_pc", pc, mpc);

    // Reset during EXEC
    run_mode = 1'b1;
    opcode   = 7'h13;
    wait_fetch(25, w);
    cyc();
    chk("pre_rst_exec", state, 2);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("rst_exec_state", state, 0);
    chk("rst_exec_pc", pc, 0);
    bad = 0;
    repeat (4) begin if (reg_we || step_done) bad++; cyc(); end
    chk("rst_exec_no_write", bad, 0);

    // Reset during WB: commit of pc 4->8 must be discarded
    wait_fetch(25, w);
    if (ir_load) run_instr(7'h13, 32'd0, 32'd4, 1'b1);
    wait_fetch(25, w);
    cyc();
    cyc();
    chk("pre_rst_wb", state, 3);
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    chk("rst_wb_state", state, 0);
    chk("rst_wb_pc", pc, 0);
    chk("rst_wb_strobes", {reg_we, step_done}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
